// File: rtl/toggle_event_decoder.sv
// Receiver for toggle-encoded events: synchronises the toggle line, converts
// each level change to a one-cycle pulse, counts events and queues them for a consumer.
module toggle_event_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int PEND_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tog_in,
    output logic              ev_pulse,
    output logic [CNT_W-1:0]  ev_count,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = {{(PEND_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_q;
    logic                   hist;
    logic                   tog_edge;
    logic                   inc;
    logic                   dec;

    assign sync_q   = sync_r[SYNC_STAGES-1];
    assign tog_edge = sync_q ^ hist;
    assign inc      = tog_edge;
    assign dec      = ev_valid && ev_ready;
    assign ev_valid = (pending != '0);

    // Bit 0 is the metastability-catching stage; the line shifts toward the MSB.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r <= '0;
            hist   <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], tog_in};
            hist   <= sync_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ev_pulse <= 1'b0;
            ev_count <= '0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            ev_pulse <= tog_edge;
            if (tog_edge)
                ev_count <= ev_count + CNT_ONE;
            // A simultaneous event and accept leaves the queue level unchanged,
            // so a full queue only loses an event when nothing drains that cycle.
            case ({inc, dec})
                2'b10: begin
                    if (pending == PEND_MAX)
                        overflow <= 1'b1;
                    else
                        pending <= pending + PEND_ONE;
                end
                2'b01:   pending <= pending - PEND_ONE;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Scoreboard bench for toggle_event_decoder: each driven toggle queues the
// expected count value and pulse cycle; the monitor pops and compares on every pulse.
module tb_toggle_event_decoder;

    localparam int S  = 2;
    localparam int CW = 8;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          tog_in;
    logic          ev_pulse;
    logic [CW-1:0] ev_count;
    logic          ev_valid;
    logic          ev_ready;
    logic [PW-1:0] pending;
    logic          overflow;

    typedef struct {
        int cnt;
        int cyc;
    } ev_t;

    ev_t sb[$];
    ev_t mon_e;
    int  cyc = 0;
    int  exp_cnt = 0;
    int  checks = 0;
    int  errors = 0;

    toggle_event_decoder #(.SYNC_STAGES(S), .CNT_W(CW), .PEND_W(PW)) dut (
        .clk(clk), .reset(reset), .tog_in(tog_in), .ev_pulse(ev_pulse),
        .ev_count(ev_count), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .pending(pending), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after a clock edge; pulse is due SYNC_STAGES+1 edges later.
    task automatic push_ev();
        ev_t e;
        exp_cnt = (exp_cnt + 1) % (1 << CW);
        e.cnt = exp_cnt;
        e.cyc = cyc + 1 + S;
        sb.push_back(e);
    endtask

    task automatic toggle();
        tog_in = ~tog_in;
        push_ev();
    endtask

    task automatic do_reset(input logic lvl);
        reset  = 1'b1;
        tog_in = lvl;
        sb.delete();
        exp_cnt = 0;
        tick();
        reset = 1'b0;
        if (lvl) push_ev();
    endtask

    task automatic chk_state(input string tag, input int p, input int v, input int o);
        chk({tag, "_pend"}, int'(pending), p);
        chk({tag, "_vld"},  int'(ev_valid), v);
        chk({tag, "_ovf"},  int'(overflow), o);
    endtask

    always @(negedge clk) begin
        if (!reset && ev_pulse) begin
            if (sb.size() == 0) begin
                chk("pulse_unexp", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("pulse_cnt", int'(ev_count), mon_e.cnt);
                chk("pulse_cyc", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        reset = 1'b1; tog_in = 1'b0; ev_ready = 1'b0;
        // 1: reset held 10 cycles
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("rst_pulse", int'(ev_pulse), 0);
            chk("rst_cnt", int'(ev_count), 0);
            chk_state("rst", 0, 0, 0);
        end
        reset = 1'b0;
        repeat (3) tick();

        // 2: single toggle
        toggle();
        repeat (5) tick();
        chk("t2_cnt", int'(ev_count), 1);
        chk_state("t2", 1, 1, 0);
        ev_ready = 1'b1; tick(); ev_ready = 1'b0;
        chk_state("t2_drain", 0, 0, 0);

        // 3: five back-to-back toggles, then drain
        for (int i = 0; i < 5; i++) begin
            toggle();
            tick();
        end
        repeat (4) tick();
        chk("t3_cnt", int'(ev_count), 6);
        chk_state("t3", 5, 1, 0);
        ev_ready = 1'b1;
        for (int i = 4; i >= 0; i--) begin
            tick();
            chk("t3_drain", int'(pending), i);
        end
        chk("t3_vld", int'(ev_valid), 0);
        ev_ready = 1'b0;

        // 4: saturation and sticky overflow
        do_reset(1'b0);
        for (int i = 0; i < 16; i++) begin
            toggle();
            tick();
        end
        repeat (4) tick();
        chk("t4_cnt", int'(ev_count), 16);
        chk_state("t4_full", 15, 1, 1);
        ev_ready = 1'b1;
        for (int i = 14; i >= 0; i--) begin
            tick();
            chk("t4_drain", int'(pending), i);
        end
        repeat (2) tick();
        chk_state("t4_empty", 0, 0, 1);
        ev_ready = 1'b0;

        // 5a: event and accept coincide with pending=3
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) begin
            toggle();
            tick();
        end
        repeat (4) tick();
        chk_state("t5_pre", 3, 1, 0);
        toggle();
        tick(); tick();
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        chk("t5_pulse", int'(ev_pulse), 1);
        chk("t5_cnt", int'(ev_count), 4);
        chk_state("t5", 3, 1, 0);

        // 5b: same coincidence at full queue must not flag overflow
        do_reset(1'b0);
        for (int i = 0; i < 15; i++) begin
            toggle();
            tick();
        end
        repeat (4) tick();
        chk_state("t5f_pre", 15, 1, 0);
        toggle();
        tick(); tick();
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        chk_state("t5f", 15, 1, 0);
        repeat (3) tick();

        // reset with the line high reports one event after release
        do_reset(1'b1);
        repeat (5) tick();
        chk("align_cnt", int'(ev_count), 1);
        chk_state("align", 1, 1, 0);

        // 6: counter wrap, then reset with events queued
        do_reset(1'b0);
        for (int i = 0; i < 255; i++) begin
            toggle();
            tick();
        end
        repeat (4) tick();
        chk("t6_cnt255", int'(ev_count), 255);
        toggle();
        repeat (5) tick();
        chk("t6_wrap", int'(ev_count), 0);
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) begin
            toggle();
            tick();
        end
        repeat (4) tick();
        chk_state("t6_pre", 4, 1, 0);
        do_reset(1'b0);
        chk("t6_cnt", int'(ev_count), 0);
        chk_state("t6_rst", 0, 0, 0);
        repeat (5) tick();

        chk("sb_left", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
